// File: rtl/usb2_ep_ctrl.sv
// Endpoint controller between usb2_packet and the application endpoint buffers.
// Holds per-endpoint mode/toggle/RX/TX state and presents the selected endpoint's status.
module usb2_ep_ctrl #(
  parameter int NUM_EP = 4
) (
  input  logic                   phy_clk,
  input  logic                   reset,
  input  logic [3:0]             sel_endp,
  output logic [1:0]             endp_mode,
  output logic [1:0]             data_toggle,
  input  logic                   data_toggle_act,
  output logic                   buf_in_ready,
  input  logic                   buf_in_commit,
  input  logic [9:0]             buf_in_commit_len,
  output logic                   buf_in_commit_ack,
  output logic                   buf_out_hasdata,
  output logic [9:0]             buf_out_len,
  input  logic                   buf_out_arm,
  output logic                   buf_out_arm_ack,
  input  logic                   cfg_wr,
  input  logic [3:0]             cfg_ep,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_toggle,
  output logic [NUM_EP-1:0]      rx_full,
  output logic [10*NUM_EP-1:0]   rx_len,
  input  logic [NUM_EP-1:0]      rx_release,
  input  logic [NUM_EP-1:0]      tx_load,
  input  logic [10*NUM_EP-1:0]   tx_len,
  output logic [NUM_EP-1:0]      tx_done
);

  typedef enum logic [1:0] {
    MODE_CONTROL   = 2'd0,
    MODE_ISOCH     = 2'd1,
    MODE_BULK      = 2'd2,
    MODE_INTERRUPT = 2'd3
  } ep_mode_e;

  ep_mode_e                mode_q   [NUM_EP];
  ep_mode_e                mode_d   [NUM_EP];
  logic [NUM_EP-1:0]       toggle_q, toggle_d;
  logic [NUM_EP-1:0]       full_q, full_d;
  logic [NUM_EP-1:0]       loaded_q, loaded_d;
  logic [10*NUM_EP-1:0]    rxlen_q, rxlen_d;
  logic [10*NUM_EP-1:0]    txlen_q, txlen_d;
  logic [NUM_EP-1:0]       tx_done_d;
  logic [3:0]              sel_q;

  ep_mode_e                mux_mode;
  logic [1:0]              mux_toggle;
  logic                    mux_ready;
  logic                    mux_hasdata;
  logic [9:0]              mux_len;

  // Per-EP next state. Ordering inside each iteration sets the priorities:
  // release before commit, arm before load, toggle before configuration.
  always_comb begin
    mode_d    = mode_q;
    toggle_d  = toggle_q;
    full_d    = full_q;
    loaded_d  = loaded_q;
    rxlen_d   = rxlen_q;
    txlen_d   = txlen_q;
    tx_done_d = '0;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      if (rx_release[i]) begin
        full_d[i] = 1'b0;
      end
      if (buf_in_commit && (sel_endp == 4'(i)) && !full_d[i]) begin
        full_d[i]            = 1'b1;
        rxlen_d[10*i +: 10]  = buf_in_commit_len;
      end
      if (buf_out_arm && (sel_endp == 4'(i))) begin
        loaded_d[i]  = 1'b0;
        tx_done_d[i] = 1'b1;
      end
      if (tx_load[i]) begin
        loaded_d[i]         = 1'b1;
        txlen_d[10*i +: 10] = tx_len[10*i +: 10];
      end
      if (data_toggle_act && (sel_endp == 4'(i)) && (mode_q[i] != MODE_ISOCH)) begin
        toggle_d[i] = ~toggle_q[i];
      end
      if (cfg_wr && (cfg_ep == 4'(i))) begin
        mode_d[i]   = ep_mode_e'(cfg_mode);
        toggle_d[i] = cfg_toggle;
      end
    end
  end

  // Status of the endpoint captured in sel_q; unmatched numbers give the invalid-EP view.
  always_comb begin
    mux_mode    = MODE_BULK;
    mux_toggle  = 2'b00;
    mux_ready   = 1'b0;
    mux_hasdata = 1'b0;
    mux_len     = '0;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      if (sel_q == 4'(i)) begin
        mux_mode    = mode_q[i];
        mux_toggle  = (mode_q[i] == MODE_ISOCH) ? 2'b00 : {1'b0, toggle_q[i]};
        mux_ready   = ~full_q[i];
        mux_hasdata = loaded_q[i];
        mux_len     = txlen_q[10*i +: 10];
      end
    end
  end

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_EP; i++) begin
        mode_q[i] <= MODE_CONTROL;
      end
      toggle_q          <= '0;
      full_q            <= '0;
      loaded_q          <= '0;
      rxlen_q           <= '0;
      txlen_q           <= '0;
      sel_q             <= '0;
      endp_mode         <= '0;
      data_toggle       <= '0;
      buf_in_ready      <= 1'b0;
      buf_out_hasdata   <= 1'b0;
      buf_out_len       <= '0;
      buf_in_commit_ack <= 1'b0;
      buf_out_arm_ack   <= 1'b0;
      tx_done           <= '0;
    end else begin
      mode_q            <= mode_d;
      toggle_q          <= toggle_d;
      full_q            <= full_d;
      loaded_q          <= loaded_d;
      rxlen_q           <= rxlen_d;
      txlen_q           <= txlen_d;
      sel_q             <= sel_endp;
      endp_mode         <= mux_mode;
      data_toggle       <= mux_toggle;
      buf_in_ready      <= mux_ready;
      buf_out_hasdata   <= mux_hasdata;
      buf_out_len       <= mux_len;
      buf_in_commit_ack <= buf_in_commit;
      buf_out_arm_ack   <= buf_out_arm;
      tx_done           <= tx_done_d;
    end
  end

  assign rx_full = full_q;
  assign rx_len  = rxlen_q;

endmodule

// File: tb/tb_usb2_ep_ctrl.sv
// Bench for usb2_ep_ctrl: directed vector table, hand sequences and a randomized
// run checked against a per-endpoint behavioural model.
module tb_usb2_ep_ctrl;

  localparam int NEP = 4;

  logic             phy_clk = 1'b0;
  logic             reset;
  logic [3:0]       sel_endp;
  logic [1:0]       endp_mode;
  logic [1:0]       data_toggle;
  logic             data_toggle_act;
  logic             buf_in_ready;
  logic             buf_in_commit;
  logic [9:0]       buf_in_commit_len;
  logic             buf_in_commit_ack;
  logic             buf_out_hasdata;
  logic [9:0]       buf_out_len;
  logic             buf_out_arm;
  logic             buf_out_arm_ack;
  logic             cfg_wr;
  logic [3:0]       cfg_ep;
  logic [1:0]       cfg_mode;
  logic             cfg_toggle;
  logic [NEP-1:0]   rx_full;
  logic [10*NEP-1:0] rx_len;
  logic [NEP-1:0]   rx_release;
  logic [NEP-1:0]   tx_load;
  logic [10*NEP-1:0] tx_len;
  logic [NEP-1:0]   tx_done;

  usb2_ep_ctrl #(.NUM_EP(NEP)) dut (
    .phy_clk(phy_clk), .reset(reset), .sel_endp(sel_endp),
    .endp_mode(endp_mode), .data_toggle(data_toggle), .data_toggle_act(data_toggle_act),
    .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
    .buf_out_hasdata(buf_out_hasdata), .buf_out_len(buf_out_len),
    .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack),
    .cfg_wr(cfg_wr), .cfg_ep(cfg_ep), .cfg_mode(cfg_mode), .cfg_toggle(cfg_toggle),
    .rx_full(rx_full), .rx_len(rx_len), .rx_release(rx_release),
    .tx_load(tx_load), .tx_len(tx_len), .tx_done(tx_done)
  );

  always #5 phy_clk = ~phy_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [1:0]  m_mode   [NEP];
  logic        m_tog    [NEP];
  logic        m_full   [NEP];
  logic        m_loaded [NEP];
  logic [9:0]  m_rxl    [NEP];
  logic [9:0]  m_txl    [NEP];
  logic [3:0]  m_psel;
  logic        e_cack, e_aack, e_rdy, e_hd;
  logic [NEP-1:0] e_txd;
  logic [1:0]  e_mode, e_tog;
  logic [9:0]  e_olen;

  task automatic model_edge();
    int ep;
    bit valid;
    if (reset) begin
      for (int n = 0; n < NEP; n++) begin
        m_mode[n] = 0; m_tog[n] = 0; m_full[n] = 0; m_loaded[n] = 0; m_rxl[n] = 0; m_txl[n] = 0;
      end
      m_psel = 0; e_cack = 0; e_aack = 0; e_txd = 0;
      e_mode = 0; e_tog = 0; e_rdy = 0; e_hd = 0; e_olen = 0;
    end else begin
      // status view of the previously selected endpoint, from the state before this edge
      if (int'(m_psel) < NEP) begin
        e_mode = m_mode[m_psel];
        e_tog  = (m_mode[m_psel] == 2'd1) ? 2'd0 : {1'b0, m_tog[m_psel]};
        e_rdy  = !m_full[m_psel];
        e_hd   = m_loaded[m_psel];
        e_olen = m_txl[m_psel];
      end else begin
        e_mode = 2'd2; e_tog = 0; e_rdy = 0; e_hd = 0; e_olen = 0;
      end
      m_psel = sel_endp;
      e_cack = buf_in_commit;
      e_aack = buf_out_arm;
      e_txd  = 0;
      ep     = int'(sel_endp);
      valid  = ep < NEP;
      for (int n = 0; n < NEP; n++) if (rx_release[n]) m_full[n] = 0;
      if (buf_in_commit && valid) begin
        if (!m_full[ep]) begin m_full[ep] = 1; m_rxl[ep] = buf_in_commit_len; end
      end
      if (buf_out_arm && valid) begin m_loaded[ep] = 0; e_txd[ep] = 1'b1; end
      for (int n = 0; n < NEP; n++) begin
        if (tx_load[n]) begin m_loaded[n] = 1; m_txl[n] = tx_len[10*n +: 10]; end
      end
      if (data_toggle_act && valid) begin
        if (m_mode[ep] != 2'd1) m_tog[ep] = !m_tog[ep];
      end
      if (cfg_wr && int'(cfg_ep) < NEP) begin
        m_mode[cfg_ep] = cfg_mode;
        m_tog[cfg_ep]  = cfg_toggle;
      end
    end
  endtask

  task automatic model_check();
    logic [NEP-1:0]    e_rxf;
    logic [10*NEP-1:0] e_rxlen;
    for (int n = 0; n < NEP; n++) begin
      e_rxf[n] = m_full[n];
      e_rxlen[10*n +: 10] = m_rxl[n];
    end
    chk("model commit_ack", buf_in_commit_ack, e_cack);
    chk("model arm_ack", buf_out_arm_ack, e_aack);
    chk("model tx_done", tx_done, e_txd);
    chk("model rx_full", rx_full, e_rxf);
    chk("model rx_len", rx_len, e_rxlen);
    chk("model endp_mode", endp_mode, e_mode);
    chk("model data_toggle", data_toggle, e_tog);
    chk("model buf_in_ready", buf_in_ready, e_rdy);
    chk("model buf_out_hasdata", buf_out_hasdata, e_hd);
    chk("model buf_out_len", buf_out_len, e_olen);
  endtask

  task automatic cycle();
    @(posedge phy_clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic idle();
    data_toggle_act = 0; buf_in_commit = 0; buf_in_commit_len = 0; buf_out_arm = 0;
    cfg_wr = 0; cfg_ep = 0; cfg_mode = 0; cfg_toggle = 0;
    rx_release = 0; tx_load = 0; tx_len = 0;
  endtask

  task automatic rand_inputs();
    sel_endp = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
    buf_in_commit     = ($urandom_range(0, 2) == 0);
    buf_in_commit_len = 10'($urandom);
    buf_out_arm       = ($urandom_range(0, 2) == 0);
    data_toggle_act   = ($urandom_range(0, 2) == 0);
    cfg_wr            = ($urandom_range(0, 5) == 0);
    cfg_ep            = 4'($urandom_range(0, 5));
    cfg_mode          = 2'($urandom);
    cfg_toggle        = 1'($urandom);
    for (int n = 0; n < NEP; n++) begin
      rx_release[n] = ($urandom_range(0, 3) == 0);
      tx_load[n]    = ($urandom_range(0, 3) == 0);
    end
    tx_len = {8'($urandom), $urandom};
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] sel; logic commit; logic [9:0] clen; logic [3:0] rel; logic [3:0] load;
    logic [9:0] tlen; logic arm; logic act; logic cfg; logic [3:0] cep; logic [1:0] cmode;
    logic ctog;
    logic cack; logic aack; logic [3:0] txd; logic [3:0] rxf; logic [9:0] rxl0; logic [9:0] rxl1;
    logic rdy; logic hd; logic [9:0] olen; logic [1:0] mode; logic [1:0] tog;
  } vec_t;

  vec_t tbl [30];

  initial begin
    // inputs: sel commit clen rel load tlen arm act cfg cep cmode ctog
    // expect: cack aack txd rxf rxl0 rxl1 rdy hd olen mode tog
    tbl[0]  = '{4'd1,1'b1,10'd64,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b1,1'b0,4'h0,4'h2,10'd0,10'd64,1'b1,1'b0,10'd0,2'd0,2'd0};
    tbl[1]  = '{4'd1,1'b1,10'd8,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b1,1'b0,4'h0,4'h2,10'd0,10'd64,1'b0,1'b0,10'd0,2'd0,2'd0};
    tbl[2]  = '{4'd1,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h2,10'd0,10'd64,1'b0,1'b0,10'd0,2'd0,2'd0};
    tbl[3]  = '{4'd1,1'b0,10'd0,4'h2,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b0,1'b0,10'd0,2'd0,2'd0};
    tbl[4]  = '{4'd1,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd0,2'd0};
    tbl[5]  = '{4'd2,1'b0,10'd0,4'h0,4'h4,10'd512,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd0,2'd0};
    tbl[6]  = '{4'd2,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b1,10'd512,2'd0,2'd0};
    tbl[7]  = '{4'd2,1'b0,10'd0,4'h0,4'h0,10'd0,1'b1,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b1,4'h4,4'h0,10'd0,10'd64,1'b1,1'b1,10'd512,2'd0,2'd0};
    tbl[8]  = '{4'd2,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd512,2'd0,2'd0};
    tbl[9]  = '{4'd2,1'b0,10'd0,4'h0,4'h4,10'd100,1'b1,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b1,4'h4,4'h0,10'd0,10'd64,1'b1,1'b0,10'd512,2'd0,2'd0};
    tbl[10] = '{4'd2,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b1,10'd100,2'd0,2'd0};
    tbl[11] = '{4'd2,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b1,10'd100,2'd0,2'd0};
    tbl[12] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b1,4'd3,2'd2,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b1,10'd100,2'd0,2'd0};
    tbl[13] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b1,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd2,2'd0};
    tbl[14] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b1,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd2,2'd1};
    tbl[15] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b1,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd2,2'd0};
    tbl[16] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd2,2'd1};
    tbl[17] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b1,4'd3,2'd1,1'b1, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd2,2'd1};
    tbl[18] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b1,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd1,2'd0};
    tbl[19] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b1,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd1,2'd0};
    tbl[20] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd1,2'd0};
    tbl[21] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b1,4'd3,2'd2,1'b1, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd1,2'd0};
    tbl[22] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b1,1'b1,4'd3,2'd2,1'b1, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd2,2'd1};
    tbl[23] = '{4'd3,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd2,2'd1};
    tbl[24] = '{4'd9,1'b1,10'd33,4'h0,4'h0,10'd0,1'b1,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b1,1'b1,4'h0,4'h0,10'd0,10'd64,1'b1,1'b0,10'd0,2'd2,2'd1};
    tbl[25] = '{4'd9,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b0,1'b0,10'd0,2'd2,2'd0};
    tbl[26] = '{4'd9,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b1,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h0,10'd0,10'd64,1'b0,1'b0,10'd0,2'd2,2'd0};
    tbl[27] = '{4'd0,1'b1,10'd10,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b1,1'b0,4'h0,4'h1,10'd10,10'd64,1'b0,1'b0,10'd0,2'd2,2'd0};
    tbl[28] = '{4'd0,1'b1,10'd20,4'h1,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b1,1'b0,4'h0,4'h1,10'd20,10'd64,1'b0,1'b0,10'd0,2'd0,2'd0};
    tbl[29] = '{4'd0,1'b0,10'd0,4'h0,4'h0,10'd0,1'b0,1'b0,1'b0,4'd0,2'd0,1'b0, 1'b0,1'b0,4'h0,4'h1,10'd20,10'd64,1'b0,1'b0,10'd0,2'd0,2'd0};

    // reset held three cycles with random inputs
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_inputs();
      cycle();
      chk("reset commit_ack", buf_in_commit_ack, 0);
      chk("reset arm_ack", buf_out_arm_ack, 0);
      chk("reset tx_done", tx_done, 0);
      chk("reset rx_full", rx_full, 0);
      chk("reset rx_len", rx_len, 0);
      chk("reset endp_mode", endp_mode, 0);
      chk("reset data_toggle", data_toggle, 0);
      chk("reset buf_in_ready", buf_in_ready, 0);
      chk("reset buf_out_hasdata", buf_out_hasdata, 0);
      chk("reset buf_out_len", buf_out_len, 0);
    end
    reset = 1'b0;
    sel_endp = 4'd0;
    idle();
    cycle();
    cycle();
    chk("post-reset endp_mode", endp_mode, 0);
    chk("post-reset buf_in_ready", buf_in_ready, 1);

    for (int r = 0; r < 30; r++) begin
      sel_endp = tbl[r].sel; buf_in_commit = tbl[r].commit; buf_in_commit_len = tbl[r].clen;
      rx_release = tbl[r].rel; tx_load = tbl[r].load; tx_len = {4{tbl[r].tlen}};
      buf_out_arm = tbl[r].arm; data_toggle_act = tbl[r].act; cfg_wr = tbl[r].cfg;
      cfg_ep = tbl[r].cep; cfg_mode = tbl[r].cmode; cfg_toggle = tbl[r].ctog;
      cycle();
      chk($sformatf("row%0d commit_ack", r), buf_in_commit_ack, tbl[r].cack);
      chk($sformatf("row%0d arm_ack", r), buf_out_arm_ack, tbl[r].aack);
      chk($sformatf("row%0d tx_done", r), tx_done, tbl[r].txd);
      chk($sformatf("row%0d rx_full", r), rx_full, tbl[r].rxf);
      chk($sformatf("row%0d rx_len0", r), rx_len[9:0], tbl[r].rxl0);
      chk($sformatf("row%0d rx_len1", r), rx_len[19:10], tbl[r].rxl1);
      chk($sformatf("row%0d buf_in_ready", r), buf_in_ready, tbl[r].rdy);
      chk($sformatf("row%0d buf_out_hasdata", r), buf_out_hasdata, tbl[r].hd);
      chk($sformatf("row%0d buf_out_len", r), buf_out_len, tbl[r].olen);
      chk($sformatf("row%0d endp_mode", r), endp_mode, tbl[r].mode);
      chk($sformatf("row%0d data_toggle", r), data_toggle, tbl[r].tog);
    end

    // reset asserted in the same cycle as commit and arm on EP0
    idle();
    sel_endp = 4'd0;
    rx_release = 4'b0001;
    cycle();
    idle();
    reset = 1'b1;
    buf_in_commit = 1'b1; buf_in_commit_len = 10'd77; buf_out_arm = 1'b1;
    cycle();
    chk("midreset commit_ack", buf_in_commit_ack, 0);
    chk("midreset arm_ack", buf_out_arm_ack, 0);
    chk("midreset tx_done", tx_done, 0);
    chk("midreset rx_full", rx_full, 0);
    reset = 1'b0;
    idle();
    cycle();
    chk("after-midreset rx_full", rx_full, 0);
    chk("after-midreset commit_ack", buf_in_commit_ack, 0);

    // randomized traffic including occasional resets
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
